// File: rtl/mipi_tx_framer_if.sv
// Pixel-stream input, control and link-output signals of the camera framer.
interface mipi_tx_framer_if;
    logic        START;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic [3:0]  CAM_DATA;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [9:0]  LINE_IDX;
    logic        UNDERFLOW;

    // Pixel source / controller side
    modport master (
        output START, PIX_DATA, PIX_VALID,
        input  PIX_READY, CAM_DATA, BUSY, FRAME_DONE, LINE_IDX, UNDERFLOW
    );

    // Framer side
    modport slave (
        input  START, PIX_DATA, PIX_VALID,
        output PIX_READY, CAM_DATA, BUSY, FRAME_DONE, LINE_IDX, UNDERFLOW
    );
endinterface

// File: rtl/mipi_tx_framer.sv
// Camera-side 4-lane nibble link transmitter: VSYNC once per frame, then
// HSYNC + DATA packets per line, each packet followed by idle gap nibbles.
module mipi_tx_framer #(
    parameter int unsigned LINE_PIXELS = 960,
    parameter int unsigned FRAME_LINES = 4,
    parameter int unsigned GAP_NIBBLES = 1,
    parameter logic [3:0]  IDLE_NIB    = 4'b0101
) (
    input  logic            CAM_CLK,
    input  logic            RESET_N,
    mipi_tx_framer_if.slave bus
);

    localparam int unsigned NIB_W  = 5;
    localparam int unsigned PIX_W  = 10;
    localparam int unsigned LINE_W = 10;

    localparam logic [NIB_W-1:0]  SYNC_LAST = NIB_W'(15);
    localparam logic [NIB_W-1:0]  HDR_LAST  = NIB_W'(19);
    localparam logic [NIB_W-1:0]  GAP_LAST  = NIB_W'(GAP_NIBBLES - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    localparam logic [7:0] SYNC_BYTE = 8'h1D;
    localparam logic [7:0] ID_VSYNC  = 8'h00;
    localparam logic [7:0] ID_HSYNC  = 8'h40;
    localparam logic [7:0] ID_DATA   = 8'h54;

    // S_ARM is the launch slot between START accept and the first VSYNC nibble
    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_VS_PKT, S_VS_GAP, S_HS_PKT, S_HS_GAP,
        S_DT_HDR, S_DT_PAY, S_LN_GAP
    } state_t;

    state_t              state, state_n;
    logic [NIB_W-1:0]    nib_cnt, nib_n;
    logic [1:0]          pix_nib, pix_nib_n;
    logic [PIX_W-1:0]    pix_cnt, pix_cnt_n;
    logic [LINE_W-1:0]   line_idx, line_n;
    logic [15:0]         sreg, sreg_n;
    logic [3:0]          cam_data, cam_n;
    logic                pix_ready, pix_ready_n;
    logic                busy, busy_n;
    logic                frame_done, frame_done_n;
    logic                underflow, underflow_n;

    // Header nibble idx of a sync header (bytes 00,00,1D,id) plus trailing 1111s
    function automatic logic [3:0] hdr_nib(input logic [7:0] id, input logic [NIB_W-1:0] idx);
        logic [7:0] b;
        logic [1:0] d;
        logic [3:0] n;
        case (idx[3:2])
            2'd2:    b = SYNC_BYTE;
            2'd3:    b = id;
            default: b = 8'h00;
        endcase
        case (idx[1:0])
            2'd0:    d = b[7:6];
            2'd1:    d = b[5:4];
            2'd2:    d = b[3:2];
            default: d = b[1:0];
        endcase
        case (d)
            2'b00:   n = 4'b0000;
            2'b01:   n = 4'b1100;
            2'b10:   n = 4'b0011;
            default: n = 4'b1111;
        endcase
        if (idx[4]) begin
            n = 4'b1111;
        end
        return n;
    endfunction

    // State register
    always_ff @(posedge CAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_n   = state;
        nib_n     = nib_cnt;
        pix_nib_n = pix_nib;
        pix_cnt_n = pix_cnt;
        line_n    = line_idx;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    state_n = S_ARM;
                    line_n  = '0;
                end
            end
            S_ARM: begin
                state_n = S_VS_PKT;
                nib_n   = '0;
            end
            S_VS_PKT, S_HS_PKT: begin
                if (nib_cnt == SYNC_LAST) begin
                    state_n = (state == S_VS_PKT) ? S_VS_GAP : S_HS_GAP;
                    nib_n   = '0;
                end else begin
                    nib_n = nib_cnt + NIB_W'(1);
                end
            end
            S_VS_GAP, S_HS_GAP: begin
                if (nib_cnt == GAP_LAST) begin
                    state_n = (state == S_VS_GAP) ? S_HS_PKT : S_DT_HDR;
                    nib_n   = '0;
                end else begin
                    nib_n = nib_cnt + NIB_W'(1);
                end
            end
            S_DT_HDR: begin
                if (nib_cnt == HDR_LAST) begin
                    state_n   = S_DT_PAY;
                    pix_cnt_n = '0;
                    pix_nib_n = '0;
                end else begin
                    nib_n = nib_cnt + NIB_W'(1);
                end
            end
            S_DT_PAY: begin
                if (pix_nib == 2'd3) begin
                    if (pix_cnt == PIX_LAST) begin
                        state_n = S_LN_GAP;
                        nib_n   = '0;
                    end else begin
                        pix_cnt_n = pix_cnt + PIX_W'(1);
                        pix_nib_n = 2'd0;
                    end
                end else begin
                    pix_nib_n = pix_nib + 2'd1;
                end
            end
            S_LN_GAP: begin
                if (nib_cnt == GAP_LAST) begin
                    nib_n = '0;
                    if (line_idx == LINE_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_HS_PKT;
                        line_n  = line_idx + LINE_W'(1);
                    end
                end else begin
                    nib_n = nib_cnt + NIB_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the pixel shift register
    always_comb begin
        sreg_n       = sreg;
        underflow_n  = underflow;
        cam_n        = IDLE_NIB;
        busy_n       = (state_n != S_IDLE);
        frame_done_n = (state == S_LN_GAP) && (state_n == S_IDLE);

        if (pix_ready) begin
            sreg_n = bus.PIX_VALID ? bus.PIX_DATA : 16'h0000;
        end else if (state == S_DT_PAY) begin
            sreg_n = {sreg[11:0], 4'h0};
        end

        if ((state == S_IDLE) && bus.START) begin
            underflow_n = 1'b0;
        end else if (pix_ready && !bus.PIX_VALID) begin
            underflow_n = 1'b1;
        end

        case (state_n)
            S_VS_PKT: cam_n = hdr_nib(ID_VSYNC, nib_n);
            S_HS_PKT: cam_n = hdr_nib(ID_HSYNC, nib_n);
            S_DT_HDR: cam_n = hdr_nib(ID_DATA, nib_n);
            S_DT_PAY: cam_n = sreg_n[15:12];
            default:  cam_n = IDLE_NIB;
        endcase

        pix_ready_n = ((state_n == S_DT_HDR) && (nib_n == HDR_LAST)) ||
                      ((state_n == S_DT_PAY) && (pix_nib_n == 2'd3) && (pix_cnt_n != PIX_LAST));
    end

    // Counters, shift register and registered outputs
    always_ff @(posedge CAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            nib_cnt    <= '0;
            pix_nib    <= '0;
            pix_cnt    <= '0;
            line_idx   <= '0;
            sreg       <= '0;
            cam_data   <= IDLE_NIB;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            nib_cnt    <= nib_n;
            pix_nib    <= pix_nib_n;
            pix_cnt    <= pix_cnt_n;
            line_idx   <= line_n;
            sreg       <= sreg_n;
            cam_data   <= cam_n;
            pix_ready  <= pix_ready_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            underflow  <= underflow_n;
        end
    end

    assign bus.CAM_DATA   = cam_data;
    assign bus.PIX_READY  = pix_ready;
    assign bus.BUSY       = busy;
    assign bus.FRAME_DONE = frame_done;
    assign bus.LINE_IDX   = line_idx;
    assign bus.UNDERFLOW  = underflow;

endmodule

// File: tb/tb_mipi_tx_framer.sv
// Randomized bench for mipi_tx_framer against a per-cycle expected-output queue.
module tb_mipi_tx_framer;

    localparam int unsigned LP   = 4;
    localparam int unsigned FL   = 3;
    localparam int unsigned GAP  = 1;
    localparam logic [3:0]  IDLE = 4'b0101;

    logic CAM_CLK = 1'b0;
    logic RESET_N = 1'b0;

    mipi_tx_framer_if bus ();

    mipi_tx_framer #(
        .LINE_PIXELS(LP),
        .FRAME_LINES(FL),
        .GAP_NIBBLES(GAP),
        .IDLE_NIB   (IDLE)
    ) dut (
        .CAM_CLK(CAM_CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CAM_CLK = ~CAM_CLK;

    // One expected link cycle; payload entries take their nibble from the pixel queue
    typedef struct {
        bit         pay;
        logic [3:0] nib;
        int         pidx;
        bit         rdy;
        bit         busy;
        bit         fd;
        int         line;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] pix_q[$];
    bit          m_uf;
    int          m_line;
    int          checks;
    int          failures;
    logic [15:0] pat[4];
    int          pat_i;
    logic [3:0]  dmap[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t idle_e(input int line);
        exp_t e;
        e.pay = 0; e.nib = IDLE; e.pidx = 0; e.rdy = 0; e.busy = 0; e.fd = 0; e.line = line;
        return e;
    endfunction

    task automatic push_e(input bit pay, input logic [3:0] nib, input int pidx,
                          input bit rdy, input bit busy, input bit fd, input int line);
        exp_t e;
        e.pay = pay; e.nib = nib; e.pidx = pidx; e.rdy = rdy;
        e.busy = busy; e.fd = fd; e.line = line;
        exp_q.push_back(e);
    endtask

    // Sync header 00,00,1D,id as dibit nibbles, then 'ones' nibbles of 1111 (last one requests a pixel)
    task automatic push_hdr(input logic [7:0] id, input int line, input int ones);
        logic [7:0] bytes[4];
        int dib;
        bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'h1D; bytes[3] = id;
        for (int b = 0; b < 4; b++) begin
            for (int d = 3; d >= 0; d--) begin
                dib = (int'(bytes[b]) >> (2 * d)) % 4;
                push_e(0, dmap[dib], 0, 0, 1, 0, line);
            end
        end
        for (int k = 0; k < ones; k++) begin
            push_e(0, 4'hF, 0, (k == ones - 1), 1, 0, line);
        end
    endtask

    task automatic push_gap(input int line);
        for (int k = 0; k < int'(GAP); k++) push_e(0, IDLE, 0, 0, 1, 0, line);
    endtask

    // Whole frame as seen on the link from the cycle after the START-accept edge
    task automatic gen_frame();
        push_e(0, IDLE, 0, 0, 1, 0, 0);
        push_hdr(8'h00, 0, 0);
        push_gap(0);
        for (int l = 0; l < int'(FL); l++) begin
            push_hdr(8'h40, l, 0);
            push_gap(l);
            push_hdr(8'h54, l, 4);
            for (int p = 0; p < int'(LP); p++) begin
                for (int i = 0; i < 4; i++) begin
                    push_e(1, 4'h0, i, (i == 3) && (p < int'(LP) - 1), 1, 0, l);
                end
            end
            push_gap(l);
        end
        push_e(0, IDLE, 0, 0, 0, 1, int'(FL) - 1);
    endtask

    // Check this cycle, drive inputs for the next edge, advance the model
    // vmode: 0 random data, 1 random data + random drops, 2 table data, 3 table data with slot 2 dropped
    task automatic cycle(input bit start_v, input int vmode);
        logic [15:0] w;
        logic [3:0]  want_nib;
        @(negedge CAM_CLK);
        want_nib = cur.nib;
        if (cur.pay) begin
            if (pix_q.size() == 0) begin
                check("pix_queue", 32'd0, 32'd1);
            end else begin
                w = pix_q[0] >> (4 * (3 - cur.pidx));
                want_nib = w[3:0];
                if (cur.pidx == 3) void'(pix_q.pop_front());
            end
        end
        check("cam_data",   32'(bus.CAM_DATA),   32'(want_nib));
        check("pix_ready",  32'(bus.PIX_READY),  32'(cur.rdy));
        check("busy",       32'(bus.BUSY),       32'(cur.busy));
        check("frame_done", 32'(bus.FRAME_DONE), 32'(cur.fd));
        check("line_idx",   32'(bus.LINE_IDX),   32'(cur.line));
        check("underflow",  32'(bus.UNDERFLOW),  32'(m_uf));

        bus.START     = start_v;
        bus.PIX_DATA  = (vmode >= 2) ? pat[pat_i % 4] : 16'($urandom);
        case (vmode)
            1:       bus.PIX_VALID = ($urandom_range(0, 3) != 0);
            3:       bus.PIX_VALID = !(cur.rdy && (pat_i % 4 == 2));
            default: bus.PIX_VALID = 1'b1;
        endcase

        if (cur.rdy) begin
            pix_q.push_back(bus.PIX_VALID ? bus.PIX_DATA : 16'h0000);
            if (!bus.PIX_VALID) m_uf = 1'b1;
            if (vmode >= 2) pat_i++;
        end
        if (exp_q.size() == 0 && start_v && RESET_N) begin
            gen_frame();
            m_uf = 1'b0;
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            m_line = cur.line;
        end else begin
            cur = idle_e(m_line);
        end
    endtask

    // Accept one frame and run it to its FRAME_DONE cycle; optionally toggle START while busy
    task automatic run_frame(input int vmode, input bit poke_start);
        int n;
        pat_i = 0;
        cycle(1'b1, vmode);
        check("frame_accepted", 32'(exp_q.size() > 0), 32'd1);
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            cycle(poke_start ? 1'($urandom_range(0, 1)) : 1'b0, vmode);
            n++;
        end
        check("frame_timeout", 32'(n < 400), 32'd1);
        cycle(1'b0, vmode);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0;
        pat[0] = 16'h1234; pat[1] = 16'h5678; pat[2] = 16'h9ABC; pat[3] = 16'hDEF0;
        dmap[0] = 4'b0000; dmap[1] = 4'b1100; dmap[2] = 4'b0011; dmap[3] = 4'b1111;
        pat_i = 0; m_uf = 1'b0; m_line = 0;
        cur = idle_e(0);
        bus.START = 1'b0; bus.PIX_DATA = 16'h0000; bus.PIX_VALID = 1'b0;

        // Reset state
        repeat (3) cycle(1'b0, 0);
        RESET_N = 1'b1;
        repeat (2) cycle(1'b0, 0);

        // Fixed pixel pattern, all valid
        run_frame(2, 1'b0);
        repeat (2) cycle(1'b0, 0);

        // Slot 2 of every line dropped; UNDERFLOW stays set in idle
        run_frame(3, 1'b0);
        repeat (3) cycle(1'b0, 0);

        // Random data and drops, START toggled while busy
        run_frame(1, 1'b1);
        repeat (2) cycle(1'b0, 1);

        // START held high: back-to-back frames, then drain
        for (int k = 0; k < 400; k++) cycle(1'b1, 0);
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            cycle(1'b0, 0);
            n++;
        end
        check("drain_timeout", 32'(n < 400), 32'd1);
        repeat (2) cycle(1'b0, 0);

        // Asynchronous reset in the middle of the payload
        cycle(1'b1, 1);
        n = 0;
        while (!(cur.pay && cur.pidx == 2) && n < 300) begin
            cycle(1'b0, 1);
            n++;
        end
        check("reach_payload", 32'(n < 300), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("rst_cam_data", 32'(bus.CAM_DATA),  32'(IDLE));
        check("rst_busy",     32'(bus.BUSY),      32'd0);
        check("rst_pix_ready",32'(bus.PIX_READY), 32'd0);
        check("rst_underflow",32'(bus.UNDERFLOW), 32'd0);
        check("rst_line_idx", 32'(bus.LINE_IDX),  32'd0);
        exp_q.delete();
        pix_q.delete();
        m_uf = 1'b0;
        m_line = 0;
        cur = idle_e(0);
        repeat (2) cycle(1'b0, 0);
        RESET_N = 1'b1;
        run_frame(0, 1'b0);
        repeat (3) cycle(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
